// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Optional statistics counters are compiled in only when BRANCH_PREDICTOR_STATS_EN is defined.
module branch_predictor #(
  parameter int WIDTH_DATA_LENGTH = 32,
  parameter int INDEX_BITS        = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [WIDTH_DATA_LENGTH-1:0] PC_F,
  output logic                         Predicted,
  output logic [WIDTH_DATA_LENGTH-1:0] PC_Pre,
  input  logic                         Update_En,
  input  logic [WIDTH_DATA_LENGTH-1:0] PC_E,
  input  logic                         Execute,
  input  logic [WIDTH_DATA_LENGTH-1:0] PC_ALU,
  input  logic [1:0]                   Result,
  output logic [31:0]                  Br_Count,
  output logic [31:0]                  Miss_Count
);

  localparam int unsigned ENTRIES = 1 << INDEX_BITS;
  localparam int          TAG_W   = WIDTH_DATA_LENGTH - INDEX_BITS - 2;

  logic                         valid_q  [ENTRIES];
  logic [TAG_W-1:0]             tag_q    [ENTRIES];
  logic [WIDTH_DATA_LENGTH-1:0] target_q [ENTRIES];
  logic [1:0]                   ctr_q    [ENTRIES];

  logic [INDEX_BITS-1:0] f_idx;
  logic [TAG_W-1:0]      f_tag;
  logic                  f_hit;
  logic [INDEX_BITS-1:0] e_idx;
  logic [TAG_W-1:0]      e_tag;
  logic                  e_hit;
  logic [1:0]            e_ctr_next;
  logic                  e_new_target;
  logic                  unused_pc_e_low;

  assign unused_pc_e_low = ^PC_E[1:0];

  always_comb begin
    f_idx     = PC_F[INDEX_BITS+1:2];
    f_tag     = PC_F[WIDTH_DATA_LENGTH-1:INDEX_BITS+2];
    f_hit     = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    Predicted = f_hit && ctr_q[f_idx][1];
    PC_Pre    = Predicted ? target_q[f_idx] : PC_F + WIDTH_DATA_LENGTH'(4);
  end

  always_comb begin
    e_idx        = PC_E[INDEX_BITS+1:2];
    e_tag        = PC_E[WIDTH_DATA_LENGTH-1:INDEX_BITS+2];
    e_hit        = valid_q[e_idx] && (tag_q[e_idx] == e_tag);
    e_new_target = (Result == 2'b00) || (Result == 2'b11);
    e_ctr_next   = ctr_q[e_idx];
    if (Execute) begin
      if (ctr_q[e_idx] != 2'b11) e_ctr_next = ctr_q[e_idx] + 2'd1;
    end else begin
      if (ctr_q[e_idx] != 2'b00) e_ctr_next = ctr_q[e_idx] - 2'd1;
    end
  end

  // Lookup reads only registered state, so a same-cycle update is seen next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[INDEX_BITS'(i)]  <= 1'b0;
        tag_q[INDEX_BITS'(i)]    <= '0;
        target_q[INDEX_BITS'(i)] <= '0;
        ctr_q[INDEX_BITS'(i)]    <= 2'b01;
      end
    end else if (Update_En) begin
      if (e_hit) begin
        ctr_q[e_idx] <= e_ctr_next;
        if (e_new_target) target_q[e_idx] <= PC_ALU;
      end else if (Execute) begin
        valid_q[e_idx]  <= 1'b1;
        tag_q[e_idx]    <= e_tag;
        target_q[e_idx] <= PC_ALU;
        ctr_q[e_idx]    <= 2'b10;
      end
    end
  end

`ifdef BRANCH_PREDICTOR_STATS_EN
  logic [31:0] br_count_q;
  logic [31:0] miss_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      br_count_q   <= '0;
      miss_count_q <= '0;
    end else if (Update_En) begin
      br_count_q <= br_count_q + 32'd1;
      if (Result != 2'b01) miss_count_q <= miss_count_q + 32'd1;
    end
  end

  assign Br_Count   = br_count_q;
  assign Miss_Count = miss_count_q;
`else
  assign Br_Count   = '0;
  assign Miss_Count = '0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus randomized traffic
// compared against a table-of-records reference model.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] PC_F = '0;
  logic        Predicted;
  logic [31:0] PC_Pre;
  logic        Update_En = 1'b0;
  logic [31:0] PC_E = '0;
  logic        Execute = 1'b0;
  logic [31:0] PC_ALU = '0;
  logic [1:0]  Result = 2'b01;
  logic [31:0] Br_Count;
  logic [31:0] Miss_Count;

  branch_predictor #(.WIDTH_DATA_LENGTH(32), .INDEX_BITS(4)) dut (
    .clk(clk), .rst(rst), .PC_F(PC_F), .Predicted(Predicted), .PC_Pre(PC_Pre),
    .Update_En(Update_En), .PC_E(PC_E), .Execute(Execute), .PC_ALU(PC_ALU),
    .Result(Result), .Br_Count(Br_Count), .Miss_Count(Miss_Count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          valid;
    bit [31:0]   tag;
    bit [31:0]   target;
    int          ctr;
  } ent_t;

  ent_t      m [16];
  bit [31:0] m_br;
  bit [31:0] m_miss;
  bit        stats_en;
  bit        checks_on;
  int        n_checks;
  int        n_fails;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int idx_of(input bit [31:0] pc);
    return int'((pc >> 2) % 16);
  endfunction

  function automatic void model_lookup(input bit [31:0] pc, output bit p, output bit [31:0] pre);
    int i;
    bit hit;
    i   = idx_of(pc);
    hit = m[i].valid && (m[i].tag == (pc >> 6));
    p   = hit && (m[i].ctr >= 2);
    pre = p ? m[i].target : pc + 32'd4;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) begin
      m[i].valid = 0; m[i].tag = 0; m[i].target = 0; m[i].ctr = 1;
    end
    m_br = 0; m_miss = 0;
  endfunction

  function automatic void model_update(input bit r, input bit ue, input bit [31:0] pce,
                                       input bit ex, input bit [31:0] alu, input bit [1:0] res);
    int i;
    if (r) begin
      model_reset();
      return;
    end
    if (!ue) return;
    i = idx_of(pce);
    if (m[i].valid && m[i].tag == (pce >> 6)) begin
      m[i].ctr = ex ? ((m[i].ctr + 1 > 3) ? 3 : m[i].ctr + 1)
                    : ((m[i].ctr - 1 < 0) ? 0 : m[i].ctr - 1);
      if (res == 2'd0 || res == 2'd3) m[i].target = alu;
    end else if (ex) begin
      m[i].valid = 1; m[i].tag = pce >> 6; m[i].target = alu; m[i].ctr = 2;
    end
    if (stats_en) begin
      m_br = m_br + 1;
      if (res != 2'd1) m_miss = m_miss + 1;
    end
  endfunction

  // Drive one cycle of inputs, check the combinational outputs before the edge, then advance.
  task automatic cyc(input bit r, input bit [31:0] pcf, input bit ue, input bit [31:0] pce,
                     input bit ex, input bit [31:0] alu, input bit [1:0] res);
    bit        ep;
    bit [31:0] epc;
    rst = r; PC_F = pcf; Update_En = ue; PC_E = pce; Execute = ex; PC_ALU = alu; Result = res;
    #1;
    if (checks_on) begin
      model_lookup(pcf, ep, epc);
      check("pred", {63'd0, Predicted}, {63'd0, ep});
      check("pc_pre", {32'd0, PC_Pre}, {32'd0, epc});
      check("br_count", {32'd0, Br_Count}, {32'd0, m_br});
      check("miss_count", {32'd0, Miss_Count}, {32'd0, m_miss});
    end
    @(posedge clk);
    model_update(r, ue, pce, ex, alu, res);
    @(negedge clk);
  endtask

  task automatic peek(input string tag, input bit [31:0] pcf, input bit ep, input bit [31:0] epc);
    rst = 0; Update_En = 0; PC_F = pcf;
    #1;
    check({tag, "_pred"}, {63'd0, Predicted}, {63'd0, ep});
    check({tag, "_pc_pre"}, {32'd0, PC_Pre}, {32'd0, epc});
  endtask

  initial begin
    bit [31:0] pc_a, pc_b;
    n_checks = 0; n_fails = 0; checks_on = 0;
`ifdef BRANCH_PREDICTOR_STATS_EN
    stats_en = 1;
`else
    stats_en = 0;
`endif
    model_reset();
    @(negedge clk);

    cyc(1, 32'h100, 0, 0, 0, 0, 2'b01);
    checks_on = 1;
    peek("after_reset", 32'h100, 0, 32'h104);
    check("reset_br", {32'd0, Br_Count}, 64'd0);
    check("reset_miss", {32'd0, Miss_Count}, 64'd0);

    cyc(0, 32'h100, 1, 32'h100, 1, 32'h200, 2'b10);
    peek("alloc", 32'h100, 1, 32'h200);

    repeat (3) cyc(0, 32'h100, 1, 32'h100, 0, 32'h0, 2'b10);
    peek("sat_low", 32'h100, 0, 32'h104);
    repeat (4) cyc(0, 32'h100, 1, 32'h100, 1, 32'h200, 2'b01);
    peek("sat_up", 32'h100, 1, 32'h200);
    cyc(0, 32'h100, 1, 32'h100, 1, 32'h200, 2'b01);
    cyc(0, 32'h100, 1, 32'h100, 0, 32'h0, 2'b10);
    peek("sat_hold", 32'h100, 1, 32'h200);
    cyc(0, 32'h100, 1, 32'h100, 0, 32'h0, 2'b10);
    peek("sat_drop", 32'h100, 0, 32'h104);
    repeat (2) cyc(0, 32'h100, 1, 32'h100, 1, 32'h200, 2'b01);

    cyc(0, 32'h100, 1, 32'h100, 1, 32'h300, 2'b00);
    peek("wrong_tgt", 32'h100, 1, 32'h300);

    // Same-cycle lookup of an entry being replaced by an alias returns the old contents.
    rst = 0; PC_F = 32'h100; Update_En = 1; PC_E = 32'h140; Execute = 1; PC_ALU = 32'h500; Result = 2'b11;
    #1;
    check("same_cycle_old", {32'd0, PC_Pre}, 64'h300);
    cyc(0, 32'h100, 1, 32'h140, 1, 32'h500, 2'b11);
    peek("alias_evicted", 32'h100, 0, 32'h104);
    peek("alias_new", 32'h140, 1, 32'h500);

    cyc(0, 32'h180, 1, 32'h180, 0, 32'h700, 2'b01);
    peek("nt_miss_noalloc", 32'h180, 0, 32'h184);
    cyc(0, 32'h180, 0, 32'h180, 1, 32'h700, 2'b11);
    peek("upd_disabled", 32'h180, 0, 32'h184);
    peek("pc_wrap", 32'hFFFF_FFFC, 0, 32'h0);

    cyc(1, 32'h140, 1, 32'h100, 1, 32'h900, 2'b10);
    peek("rst_prio_a", 32'h100, 0, 32'h104);
    peek("rst_prio_b", 32'h140, 0, 32'h144);

    for (int k = 0; k < 5; k++)
      cyc(0, 32'h40, 1, 32'h40 + 32'(k) * 4, 1, 32'h800, (k < 2) ? 2'b10 : 2'b01);
    #1;
    check("stats_br5", {32'd0, Br_Count}, stats_en ? 64'd5 : 64'd0);
    check("stats_miss2", {32'd0, Miss_Count}, stats_en ? 64'd2 : 64'd0);
    cyc(1, 32'h40, 1, 32'h40, 1, 32'h800, 2'b10);
    #1;
    check("stats_rst_br", {32'd0, Br_Count}, 64'd0);
    check("stats_rst_miss", {32'd0, Miss_Count}, 64'd0);

    for (int k = 0; k < 600; k++) begin
      pc_a = ($urandom_range(0, 2) << 6) | ($urandom_range(0, 15) << 2);
      pc_b = ($urandom_range(0, 2) << 6) | ($urandom_range(0, 15) << 2);
      if ($urandom_range(0, 19) == 0) pc_a = 32'hFFFF_FFC0 | pc_a[5:0];
      cyc(($urandom_range(0, 59) == 0), pc_a, ($urandom_range(0, 3) != 0), pc_b,
          1'($urandom), $urandom, 2'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
